// File: rtl/game_turn_controller.sv
// ---------------------------------------------------------------------------
// game_turn_controller
//
// Purpose:
//   Sequences a tic-tac-toe game between a human player (X, always first)
//   and an external AI engine (O). The block keeps both boards and counts
//   accepted moves. It rejects moves to occupied or out-of-range cells and
//   detects wins and draws. If the AI does not answer within AI_TIMEOUT
//   cycles, it places a fallback O move in the lowest-index empty cell.
//
// Parameters:
//   AI_TIMEOUT        cycles the AI may spend in AI_WAIT before fallback
//
// Ports:
//   clk               clock, all state changes on the rising edge
//   reset             synchronous active-high reset, dominates everything
//   new_game          synchronous clear of board and state (same as reset)
//   human_move_valid  one-cycle strobe for a human move
//   human_move_idx    human cell index 0..8
//   ai_move_valid     one-cycle strobe for an AI move
//   ai_move_idx       AI cell index 0..8
//   computer_turn     high while waiting on the AI; rising edge starts it
//   board_x           cells held by X, bit n = cell n
//   board_o           cells held by O, bit n = cell n
//   move_count        number of accepted moves, 0..9
//   illegal_move      one-cycle pulse when a move is rejected
//   ai_timeout        one-cycle pulse when the fallback move is placed
//   game_over         high in DONE
//   winner            00 none, 01 X, 10 O, 11 draw
// ---------------------------------------------------------------------------
module game_turn_controller #(
    parameter int AI_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       new_game,
    input  logic       human_move_valid,
    input  logic [3:0] human_move_idx,
    input  logic       ai_move_valid,
    input  logic [3:0] ai_move_idx,
    output logic       computer_turn,
    output logic [8:0] board_x,
    output logic [8:0] board_o,
    output logic [3:0] move_count,
    output logic       illegal_move,
    output logic       ai_timeout,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int CW = (AI_TIMEOUT > 2) ? $clog2(AI_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT_CYCLE = CW'(AI_TIMEOUT - 1);

    typedef enum logic [2:0] {
        HUMAN_WAIT,
        CHECK_X,
        AI_REQ,
        AI_WAIT,
        CHECK_O,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [8:0]    boardX_q, boardX_d;
    logic [8:0]    boardO_q, boardO_d;
    logic [3:0]    moveCount_q, moveCount_d;
    logic          illegal_q, illegal_d;
    logic          aiTimeout_q, aiTimeout_d;
    logic [1:0]    winner_q, winner_d;
    logic [CW-1:0] timeoutCnt_q, timeoutCnt_d;

    logic [15:0]   blockedCells;
    logic [8:0]    freeCells;
    logic [8:0]    fallbackMask;
    logic          humanLegal;
    logic          aiLegal;

    // True when any of the eight winning lines is fully held on board b.
    function automatic logic hasLine(input logic [8:0] b);
        return (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) |
               (b[6] & b[7] & b[8]) | (b[0] & b[3] & b[6]) |
               (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
               (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    // Legality of incoming moves and the fallback cell choice. Indices
    // 9..15 are treated as permanently blocked so one lookup covers both
    // the range check and the occupancy check. The fallback picks the
    // lowest free cell by isolating the least significant set bit.
    always_comb begin
        blockedCells = {7'h7F, boardX_q | boardO_q};
        freeCells    = ~(boardX_q | boardO_q);
        fallbackMask = freeCells & (~freeCells + 9'd1);
        humanLegal   = human_move_valid && !blockedCells[human_move_idx];
        aiLegal      = ai_move_valid && !blockedCells[ai_move_idx];
    end

    // State register plus datapath registers. Reset wins over every
    // input; new_game is folded into the next-state logic below.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= HUMAN_WAIT;
            boardX_q     <= '0;
            boardO_q     <= '0;
            moveCount_q  <= '0;
            illegal_q    <= 1'b0;
            aiTimeout_q  <= 1'b0;
            winner_q     <= 2'b00;
            timeoutCnt_q <= '0;
        end else begin
            state_q      <= state_d;
            boardX_q     <= boardX_d;
            boardO_q     <= boardO_d;
            moveCount_q  <= moveCount_d;
            illegal_q    <= illegal_d;
            aiTimeout_q  <= aiTimeout_d;
            winner_q     <= winner_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // Next-state logic. Strobes that arrive outside their own wait state
    // fall through to the defaults, so they are dropped without a pulse.
    // new_game is applied last so it overrides any move in the same cycle.
    always_comb begin
        state_d      = state_q;
        boardX_d     = boardX_q;
        boardO_d     = boardO_q;
        moveCount_d  = moveCount_q;
        illegal_d    = 1'b0;
        aiTimeout_d  = 1'b0;
        winner_d     = winner_q;
        timeoutCnt_d = timeoutCnt_q;

        case (state_q)
            HUMAN_WAIT: begin
                if (humanLegal) begin
                    boardX_d    = boardX_q | (9'd1 << human_move_idx);
                    moveCount_d = moveCount_q + 4'd1;
                    state_d     = CHECK_X;
                end else if (human_move_valid) begin
                    illegal_d = 1'b1;
                end
            end
            CHECK_X: begin
                if (hasLine(boardX_q)) begin
                    winner_d = 2'b01;
                    state_d  = DONE;
                end else if (moveCount_q == 4'd9) begin
                    winner_d = 2'b11;
                    state_d  = DONE;
                end else begin
                    state_d = AI_REQ;
                end
            end
            AI_REQ: begin
                timeoutCnt_d = '0;
                state_d      = AI_WAIT;
            end
            AI_WAIT: begin
                timeoutCnt_d = timeoutCnt_q + CW'(1);
                if (aiLegal) begin
                    boardO_d    = boardO_q | (9'd1 << ai_move_idx);
                    moveCount_d = moveCount_q + 4'd1;
                    state_d     = CHECK_O;
                end else begin
                    illegal_d = ai_move_valid;
                    if (timeoutCnt_q == LAST_WAIT_CYCLE) begin
                        boardO_d    = boardO_q | fallbackMask;
                        moveCount_d = moveCount_q + 4'd1;
                        aiTimeout_d = 1'b1;
                        state_d     = CHECK_O;
                    end
                end
            end
            CHECK_O: begin
                if (hasLine(boardO_q)) begin
                    winner_d = 2'b10;
                    state_d  = DONE;
                end else if (moveCount_q == 4'd9) begin
                    winner_d = 2'b11;
                    state_d  = DONE;
                end else begin
                    state_d = HUMAN_WAIT;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HUMAN_WAIT;
            end
        endcase

        if (new_game) begin
            state_d      = HUMAN_WAIT;
            boardX_d     = '0;
            boardO_d     = '0;
            moveCount_d  = '0;
            illegal_d    = 1'b0;
            aiTimeout_d  = 1'b0;
            winner_d     = 2'b00;
            timeoutCnt_d = '0;
        end
    end

    // Output logic. computer_turn is low in AI_REQ, so each request
    // gives the AI a fresh rising edge when AI_WAIT is entered.
    always_comb begin
        computer_turn = (state_q == AI_WAIT);
        game_over     = (state_q == DONE);
        board_x       = boardX_q;
        board_o       = boardO_q;
        move_count    = moveCount_q;
        illegal_move  = illegal_q;
        ai_timeout    = aiTimeout_q;
        winner        = winner_q;
    end

endmodule

// File: tb/tb_game_turn_controller.sv
// ---------------------------------------------------------------------------
// tb_game_turn_controller
//
// Purpose:
//   Self-checking bench for game_turn_controller. A table of per-cycle
//   vectors plays a complete X-wins game. Hand-written sequences then cover
//   the AI timeout, illegal moves, a full draw, new_game during AI_WAIT,
//   and a legal AI move arriving in the timeout cycle.
// ---------------------------------------------------------------------------
module tb_game_turn_controller;

    localparam int TO = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       human_move_valid = 1'b0;
    logic [3:0] human_move_idx = 4'd0;
    logic       ai_move_valid = 1'b0;
    logic [3:0] ai_move_idx = 4'd0;
    logic       computer_turn;
    logic [8:0] board_x;
    logic [8:0] board_o;
    logic [3:0] move_count;
    logic       illegal_move;
    logic       ai_timeout;
    logic       game_over;
    logic [1:0] winner;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic       ng;
        logic       hv;
        logic [3:0] hi;
        logic       av;
        logic [3:0] ai;
        logic [8:0] bx;
        logic [8:0] bo;
        logic [3:0] mc;
        logic       ct;
        logic       ill;
        logic       ato;
        logic       go;
        logic [1:0] win;
    } vec_t;

    vec_t vecs[15];

    game_turn_controller #(.AI_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .new_game         (new_game),
        .human_move_valid (human_move_valid),
        .human_move_idx   (human_move_idx),
        .ai_move_valid    (ai_move_valid),
        .ai_move_idx      (ai_move_idx),
        .computer_turn    (computer_turn),
        .board_x          (board_x),
        .board_o          (board_o),
        .move_count       (move_count),
        .illegal_move     (illegal_move),
        .ai_timeout       (ai_timeout),
        .game_over        (game_over),
        .winner           (winner)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge take them, then clear the
    // strobes 1 unit after the edge so outputs are sampled off the edge.
    task automatic applyStimulus(input logic ng, input logic hv, input logic [3:0] hi,
                                 input logic av, input logic [3:0] ai);
        new_game         = ng;
        human_move_valid = hv;
        human_move_idx   = hi;
        ai_move_valid    = av;
        ai_move_idx      = ai;
        @(posedge clk);
        #1;
        new_game         = 1'b0;
        human_move_valid = 1'b0;
        human_move_idx   = 4'd0;
        ai_move_valid    = 1'b0;
        ai_move_idx      = 4'd0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Human move accepted, then CHECK_X resolves (to AI_REQ or DONE).
    task automatic humanMove(input logic [3:0] idx);
        applyStimulus(1'b0, 1'b1, idx, 1'b0, 4'd0);
        idle();
    endtask

    // From AI_REQ: enter AI_WAIT, AI answers, CHECK_O resolves.
    task automatic aiMove(input logic [3:0] idx);
        idle();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, idx);
        idle();
    endtask

    initial begin
        // X wins via row 0,1,2 with O on 3 and 4; each row is one cycle.
        //            ng    hv    hi     av    ai     bx      bo      mc     ct    ill   ato   go    win
        vecs[0]  = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 9'h001, 9'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h001, 9'h000, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h001, 9'h000, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 9'h001, 9'h008, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h001, 9'h008, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 9'h003, 9'h008, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h003, 9'h008, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h003, 9'h008, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h003, 9'h008, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 9'h003, 9'h018, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h003, 9'h018, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 1'b1, 4'd2, 1'b0, 4'd0, 9'h007, 9'h018, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h007, 9'h018, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[13] = '{1'b0, 1'b1, 4'd9, 1'b0, 4'd0, 9'h007, 9'h018, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd8, 9'h007, 9'h018, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};

        // Reset asserted together with new_game and a move: reset wins.
        reset            = 1'b1;
        new_game         = 1'b1;
        human_move_valid = 1'b1;
        @(posedge clk);
        #1;
        reset            = 1'b0;
        new_game         = 1'b0;
        human_move_valid = 1'b0;
        checkOutput("reset.board_x", board_x, 0);
        checkOutput("reset.board_o", board_o, 0);
        checkOutput("reset.move_count", move_count, 0);
        checkOutput("reset.computer_turn", computer_turn, 0);
        checkOutput("reset.illegal_move", illegal_move, 0);
        checkOutput("reset.game_over", game_over, 0);
        checkOutput("reset.winner", winner, 0);

        // Table-driven X-wins game.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].ng, vecs[i].hv, vecs[i].hi, vecs[i].av, vecs[i].ai);
            checkOutput($sformatf("vec%0d.board_x", i), board_x, vecs[i].bx);
            checkOutput($sformatf("vec%0d.board_o", i), board_o, vecs[i].bo);
            checkOutput($sformatf("vec%0d.move_count", i), move_count, vecs[i].mc);
            checkOutput($sformatf("vec%0d.computer_turn", i), computer_turn, vecs[i].ct);
            checkOutput($sformatf("vec%0d.illegal_move", i), illegal_move, vecs[i].ill);
            checkOutput($sformatf("vec%0d.ai_timeout", i), ai_timeout, vecs[i].ato);
            checkOutput($sformatf("vec%0d.game_over", i), game_over, vecs[i].go);
            checkOutput($sformatf("vec%0d.winner", i), winner, vecs[i].win);
        end

        // new_game out of DONE, then AI timeout fallback.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        checkOutput("ng.game_over", game_over, 0);
        checkOutput("ng.winner", winner, 0);
        checkOutput("ng.board_x", board_x, 0);
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
        idle();
        idle();
        checkOutput("to.computer_turn_rise", computer_turn, 1);
        for (int i = 0; i < TO - 1; i++) begin
            idle();
            checkOutput($sformatf("to.wait%0d.computer_turn", i), computer_turn, 1);
            checkOutput($sformatf("to.wait%0d.ai_timeout", i), ai_timeout, 0);
        end
        idle();
        checkOutput("to.ai_timeout_pulse", ai_timeout, 1);
        checkOutput("to.board_o", board_o, 9'h001);
        checkOutput("to.move_count", move_count, 2);
        checkOutput("to.computer_turn_fall", computer_turn, 0);
        idle();
        checkOutput("to.ai_timeout_end", ai_timeout, 0);
        applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 4'd0);
        checkOutput("to.human_accepted", board_x, 9'h012);
        checkOutput("to.human_count", move_count, 3);

        // Illegal moves in HUMAN_WAIT.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        humanMove(4'd0);
        aiMove(4'd4);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
        checkOutput("ill.dup_pulse", illegal_move, 1);
        checkOutput("ill.dup_board_x", board_x, 9'h001);
        checkOutput("ill.dup_count", move_count, 2);
        idle();
        checkOutput("ill.pulse_end", illegal_move, 0);
        applyStimulus(1'b0, 1'b1, 4'd9, 1'b0, 4'd0);
        checkOutput("ill.idx9_pulse", illegal_move, 1);
        checkOutput("ill.idx9_board_x", board_x, 9'h001);
        applyStimulus(1'b0, 1'b1, 4'd4, 1'b0, 4'd0);
        checkOutput("ill.o_cell_pulse", illegal_move, 1);
        checkOutput("ill.o_cell_board_x", board_x, 9'h001);
        applyStimulus(1'b0, 1'b1, 4'd2, 1'b0, 4'd0);
        checkOutput("ill.legal_after", board_x, 9'h005);
        checkOutput("ill.legal_pulse", illegal_move, 0);
        checkOutput("ill.legal_count", move_count, 3);

        // Full draw: X 0,1,5,6,8 and O 4,2,3,7.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        humanMove(4'd0);
        aiMove(4'd4);
        humanMove(4'd1);
        aiMove(4'd2);
        humanMove(4'd5);
        aiMove(4'd3);
        humanMove(4'd6);
        aiMove(4'd7);
        humanMove(4'd8);
        checkOutput("draw.winner", winner, 2'b11);
        checkOutput("draw.game_over", game_over, 1);
        checkOutput("draw.move_count", move_count, 9);
        checkOutput("draw.board_x", board_x, 9'h163);
        checkOutput("draw.board_o", board_o, 9'h09C);
        checkOutput("draw.full", board_x | board_o, 9'h1FF);

        // new_game together with an AI move in AI_WAIT.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        humanMove(4'd0);
        idle();
        checkOutput("ngw.computer_turn_before", computer_turn, 1);
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b1, 4'd2);
        checkOutput("ngw.computer_turn", computer_turn, 0);
        checkOutput("ngw.board_x", board_x, 0);
        checkOutput("ngw.board_o", board_o, 0);
        checkOutput("ngw.move_count", move_count, 0);
        applyStimulus(1'b0, 1'b1, 4'd3, 1'b0, 4'd0);
        checkOutput("ngw.human_wait", board_x, 9'h008);

        // Legal AI move in the timeout cycle beats the fallback; a human
        // strobe during AI_WAIT is dropped silently.
        applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
        humanMove(4'd0);
        idle();
        applyStimulus(1'b0, 1'b1, 4'd8, 1'b0, 4'd0);
        checkOutput("pri.human_ignored_pulse", illegal_move, 0);
        checkOutput("pri.human_ignored_board", board_x, 9'h001);
        for (int i = 0; i < TO - 2; i++) begin
            idle();
        end
        checkOutput("pri.still_waiting", computer_turn, 1);
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 4'd5);
        checkOutput("pri.board_o", board_o, 9'h020);
        checkOutput("pri.ai_timeout", ai_timeout, 0);
        checkOutput("pri.move_count", move_count, 2);
        checkOutput("pri.computer_turn", computer_turn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
